// File: rtl/systolic_operand_feeder_pkg.sv
// Shared definitions for the systolic array operand feeder: default sizes,
// the feeder state encoding and the stream-length helper.
package systolic_pkg;

  localparam int unsigned MATRIX_SIZE_DEF  = 3;
  localparam int unsigned DATA_WIDTH_DEF   = 8;
  localparam int unsigned DRAIN_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } feeder_state_e;

  // Number of skewed operand steps needed to push an n x n pair through the array.
  function automatic int unsigned stream_len(input int unsigned n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_operand_feeder_operand_store.sv
// N x N operand register file with one write port and N combinational read
// ports. COLUMN_READ=0: port p reads row p (element mem[p][idx]), used for A.
// COLUMN_READ=1: port p reads column p (element mem[idx][p]), used for B.
module operand_store
  import systolic_pkg::*;
#(
  parameter int unsigned N           = MATRIX_SIZE_DEF,
  parameter int unsigned DW          = DATA_WIDTH_DEF,
  parameter int unsigned IW          = 2,
  parameter bit          COLUMN_READ = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [IW-1:0]   wr_row,
  input  logic [IW-1:0]   wr_col,
  input  logic [DW-1:0]   wr_data,
  input  logic [N*IW-1:0] rd_idx,
  output logic [N*DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [N][N];
  logic [DW-1:0] mem_d [N][N];

  // Next contents: a single in-range element write; out-of-range indices drop.
  always_comb begin
    mem_d = mem_q;
    if (we && (32'(wr_row) < N) && (32'(wr_col) < N)) begin
      mem_d[wr_row][wr_col] = wr_data;
    end
  end

  // Register file update; reset clears every element to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports: port p selects along its row (A) or column (B).
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < N; p++) begin
      if (32'(rd_idx[p*IW +: IW]) < N) begin
        if (COLUMN_READ) begin
          rd_data[p*DW +: DW] = mem_q[rd_idx[p*IW +: IW]][p];
        end else begin
          rd_data[p*DW +: DW] = mem_q[p][rd_idx[p*IW +: IW]];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Operand feeder for an N x N output-stationary systolic array. Holds A and B,
// and on start clears the array, streams A rows from the left and B columns
// from the top with diagonal skew and zero padding, drains, then pulses done.
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE  = MATRIX_SIZE_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic                              wr_sel,
  input  logic [$clog2(MATRIX_SIZE)-1:0]    wr_row,
  input  logic [$clog2(MATRIX_SIZE)-1:0]    wr_col,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              array_clr,
  output logic                              array_en,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] left_data,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] top_data
);

  localparam int unsigned N    = MATRIX_SIZE;
  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned IW   = $clog2(MATRIX_SIZE);
  localparam int unsigned CW   = $clog2(3 * MATRIX_SIZE);
  localparam int unsigned SLEN = stream_len(MATRIX_SIZE);

  localparam logic [CW-1:0] STEP_LAST  = CW'(SLEN - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  feeder_state_e   state_q, state_d;
  logic [CW-1:0]   step_q, step_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            array_clr_q, array_clr_d;
  logic            array_en_q, array_en_d;
  logic [N*DW-1:0] left_data_q, left_data_d;
  logic [N*DW-1:0] top_data_q, top_data_d;

  logic            wr_ok;
  logic            a_we, b_we;
  logic [N*IW-1:0] rd_idx;
  logic [N-1:0]    rd_vld;
  logic [N*DW-1:0] a_rd, b_rd;

  // Operand writes only land while idle; wr_sel picks the A or B store.
  always_comb begin
    wr_ok = wr_en && (state_q == IDLE);
    a_we  = wr_ok && !wr_sel;
    b_we  = wr_ok &&  wr_sel;
  end

  operand_store #(
    .N           (N),
    .DW          (DW),
    .IW          (IW),
    .COLUMN_READ (1'b0)
  ) u_store_a (
    .clk     (clk),
    .rst     (rst),
    .we      (a_we),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (a_rd)
  );

  operand_store #(
    .N           (N),
    .DW          (DW),
    .IW          (IW),
    .COLUMN_READ (1'b1)
  ) u_store_b (
    .clk     (clk),
    .rst     (rst),
    .we      (b_we),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (b_rd)
  );

  // Sequencer next state: IDLE -> CLEAR -> STREAM(3N-2) -> DRAIN -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = STREAM;
        step_d  = '0;
      end
      STREAM: begin
        if (step_q == STEP_LAST) begin
          state_d = DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (step_q == DRAIN_LAST) begin
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Lane p is live at step s when s == p + k for some element index k < N;
  // the same k addresses A[p][k] on the left and B[k][p] on the top.
  always_comb begin
    rd_idx = '0;
    rd_vld = '0;
    for (int p = 0; p < N; p++) begin
      for (int k = 0; k < N; k++) begin
        if (step_d == CW'(p + k)) begin
          rd_idx[p*IW +: IW] = IW'(k);
          rd_vld[p]          = 1'b1;
        end
      end
    end
  end

  // Output values for the upcoming state, so every output comes straight from a flop.
  always_comb begin
    busy_d      = (state_d == CLEAR) || (state_d == STREAM) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
    array_clr_d = (state_d == CLEAR);
    array_en_d  = (state_d == STREAM) || (state_d == DRAIN);
    left_data_d = '0;
    top_data_d  = '0;
    if (state_d == STREAM) begin
      for (int p = 0; p < N; p++) begin
        if (rd_vld[p]) begin
          left_data_d[p*DW +: DW] = a_rd[p*DW +: DW];
          top_data_d[p*DW +: DW]  = b_rd[p*DW +: DW];
        end
      end
    end
  end

  // State, step counter and registered outputs; reset aborts straight to IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      array_clr_q <= 1'b0;
      array_en_q  <= 1'b0;
      left_data_q <= '0;
      top_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      array_clr_q <= array_clr_d;
      array_en_q  <= array_en_d;
      left_data_q <= left_data_d;
      top_data_q  <= top_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign array_clr = array_clr_q;
  assign array_en  = array_en_q;
  assign left_data = left_data_q;
  assign top_data  = top_data_q;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder with a cycle scoreboard and a
// behavioural 3x3 output-stationary array driven by the feeder outputs.
module tb_systolic_operand_feeder;

  localparam int N  = 3;
  localparam int DW = 8;

  typedef struct {
    logic          busy;
    logic          done;
    logic          clr;
    logic          en;
    logic [N*DW-1:0] left;
    logic [N*DW-1:0] top;
  } cyc_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic            wr_sel;
  logic [1:0]      wr_row;
  logic [1:0]      wr_col;
  logic [DW-1:0]   wr_data;
  logic            start;
  logic            busy;
  logic            done;
  logic            array_clr;
  logic            array_en;
  logic [N*DW-1:0] left_data;
  logic [N*DW-1:0] top_data;

  int errors = 0;
  int checks = 0;

  cyc_t        sb[$];
  logic [7:0]  exp_a [N][N];
  logic [7:0]  exp_b [N][N];

  logic [31:0] acc [N][N];
  logic [7:0]  a_r [N][N];
  logic [7:0]  b_r [N][N];
  logic [7:0]  ai, bi;

  systolic_operand_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .array_clr (array_clr),
    .array_en  (array_en),
    .left_data (left_data),
    .top_data  (top_data)
  );

  always #5 clk = ~clk;

  // Behavioural output-stationary array: operands shift right/down, each PE accumulates.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ai = (j == 0) ? left_data[i*DW +: DW] : a_r[i][(j == 0) ? 0 : j-1];
        bi = (i == 0) ? top_data[j*DW +: DW]  : b_r[(i == 0) ? 0 : i-1][j];
        if (array_clr) begin
          acc[i][j] <= '0;
          a_r[i][j] <= '0;
          b_r[i][j] <= '0;
        end else if (array_en) begin
          acc[i][j] <= acc[i][j] + 32'(ai) * 32'(bi);
          a_r[i][j] <= ai;
          b_r[i][j] <= bi;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_exp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        exp_a[r][c] = '0;
        exp_b[r][c] = '0;
      end
  endtask

  // Single element write; the bench mirror follows only in-range indices.
  task automatic wr(input logic sel, input int r, input int c, input logic [7:0] v);
    wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (r < N && c < N) begin
      if (sel) exp_b[r][c] = v;
      else     exp_a[r][c] = v;
    end
  endtask

  // Expected per-cycle outputs from start acceptance through the following idle cycle.
  task automatic push_op();
    cyc_t e;
    for (int n = 0; n < 12; n++) begin
      e.busy = (n >= 0 && n <= 9);
      e.done = (n == 10);
      e.clr  = (n == 0);
      e.en   = (n >= 1 && n <= 9);
      e.left = '0;
      e.top  = '0;
      if (n >= 1 && n <= 7) begin
        for (int p = 0; p < N; p++) begin
          int k;
          k = (n - 1) - p;
          if (k >= 0 && k < N) begin
            e.left[p*DW +: DW] = exp_a[p][k];
            e.top[p*DW +: DW]  = exp_b[k][p];
          end
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic run_op(input string tag, input bit inject);
    cyc_t e;
    logic [31:0] c;
    push_op();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      e = sb.pop_front();
      chk($sformatf("%s.busy[%0d]", tag, n), 64'(busy), 64'(e.busy));
      chk($sformatf("%s.done[%0d]", tag, n), 64'(done), 64'(e.done));
      chk($sformatf("%s.clr[%0d]", tag, n), 64'(array_clr), 64'(e.clr));
      chk($sformatf("%s.en[%0d]", tag, n), 64'(array_en), 64'(e.en));
      chk($sformatf("%s.left[%0d]", tag, n), 64'(left_data), 64'(e.left));
      chk($sformatf("%s.top[%0d]", tag, n), 64'(top_data), 64'(e.top));
      if (inject && n == 3) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'h55;
        start = 1'b1;
      end
      if (inject && n == 4) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c = '0;
        for (int k = 0; k < N; k++) c = c + 32'(exp_a[i][k]) * 32'(exp_b[k][j]);
        chk($sformatf("%s.acc%0d%0d", tag, i, j), 64'(acc[i][j]), 64'(c));
      end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
    wr_data = '0; start = 1'b0;
    clear_exp();

    // Reset held two cycles while writes and start toggle.
    wr_en = 1'b1; wr_data = 8'h5A; start = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.clr", 64'(array_clr), 64'(0));
    chk("rst.en", 64'(array_en), 64'(0));
    chk("rst.left", 64'(left_data), 64'(0));
    chk("rst.top", 64'(top_data), 64'(0));
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    run_op("zero", 1'b0);

    // Identity A times B gives B; an out-of-range write is dropped.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, (r == c) ? 8'd1 : 8'd0);
        wr(1'b1, r, c, 8'(3 * r + c + 1));
      end
    wr(1'b0, 3, 0, 8'h77);
    wr(1'b1, 1, 3, 8'h77);
    run_op("ident", 1'b0);

    // Skew pattern with distinct values per element.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, 8'(10 * r + c));
        wr(1'b1, r, c, 8'(100 + 10 * r + c));
      end
    run_op("skew", 1'b0);

    // Busy guard: write and start during STREAM must have no effect.
    run_op("guard", 1'b1);
    run_op("guard2", 1'b0);

    // Max operands: each accumulator reaches 3*255*255.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, 8'hFF);
        wr(1'b1, r, c, 8'hFF);
      end
    run_op("max", 1'b0);
    chk("max.acc22_const", 64'(acc[2][2]), 64'(195075));

    // Mid-run reset at step 3, then a zero run and a fresh product.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, 8'(r + 2 * c + 1));
        wr(1'b1, r, c, 8'(7 - r - c));
      end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
    end
    chk("mid.en_before", 64'(array_en), 64'(1));
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid.busy", 64'(busy), 64'(0));
    chk("mid.en", 64'(array_en), 64'(0));
    chk("mid.clr", 64'(array_clr), 64'(0));
    chk("mid.done", 64'(done), 64'(0));
    chk("mid.left", 64'(left_data), 64'(0));
    chk("mid.top", 64'(top_data), 64'(0));
    clear_exp();
    run_op("mid_zero", 1'b0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, 8'(r + 2 * c + 1));
        wr(1'b1, r, c, 8'(7 - r - c));
      end
    run_op("mid_fresh", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
